// File: rtl/sfm_streamer_tail_mask_pkg.sv
// rtl/sfm_streamer_tail_mask_pkg.sv - softmax streamer types, constants and tail-mask helper
package sfm_streamer_tail_mask_pkg;

    // bf16 negative infinity: neutral element for max-reduction
    localparam logic [15:0] SFM_BF16_NEG_INF = 16'hFF80;

    // Upper bounds the mask helper is sized for (DW up to 512, EW up to 64)
    localparam int unsigned SFM_MAX_BW = 64;
    localparam int unsigned SFM_MAX_EB = 8;

    // Address generator fields the tail mask consumes
    typedef struct packed {
        logic [31:0] d0_len;   // job length in bytes
        logic [31:0] tot_len;  // job length in beats
    } hci_addressgen_ctrl_t;

    typedef struct packed {
        hci_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    // One bit per element: set when every byte of the element is strobed and,
    // on the final beat of a job with a byte leftover, the element lies fully
    // inside the leftover. A partially covered element is treated as invalid.
    function automatic logic [SFM_MAX_BW-1:0] sfm_elem_valid_mask(
        input logic [SFM_MAX_BW-1:0] strb,
        input int unsigned           lftovr,
        input logic                  is_final,
        input int unsigned           bw,
        input int unsigned           eb
    );
        logic [SFM_MAX_BW-1:0] mask;
        int unsigned           valid_bytes;
        mask        = '0;
        valid_bytes = (is_final && (lftovr != 0)) ? lftovr : bw;
        for (int unsigned e = 0; e < SFM_MAX_BW; e++) begin
            if (((e + 1) * eb) <= valid_bytes) begin
                mask[e] = 1'b1;
                for (int unsigned b = 0; b < SFM_MAX_EB; b++) begin
                    if ((b < eb) && !strb[e * eb + b]) begin
                        mask[e] = 1'b0;
                    end
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/sfm_streamer_tail_mask_if.sv
// rtl/sfm_streamer_tail_mask_if.sv - valid/ready data stream with byte strobes
interface sfm_streamer_tail_mask_if #(
    parameter int unsigned DW = 128
) ();
    localparam int unsigned BW = DW / 8;

    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic [BW-1:0] strb;

    modport master (
        output valid,
        output data,
        output strb,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  strb,
        output ready
    );
endinterface

// File: rtl/sfm_stream_reg_slice.sv
// rtl/sfm_stream_reg_slice.sv - one-entry full-throughput stream register slice
module sfm_stream_reg_slice #(
    parameter int unsigned DW = 128,
    parameter int unsigned BW = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic [BW-1:0] in_strb_i,
    input  logic          in_side_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [BW-1:0] out_strb_o,
    output logic          out_side_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [BW-1:0] strb_q, strb_d;
    logic          side_q, side_d;

    // Accept whenever the slot is empty or is being drained this cycle
    assign in_ready_o = ~valid_q | out_ready_i;

    // Next state: clear wins, then load (replaces a draining beat), then drain
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        side_d  = side_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
            strb_d  = '0;
            side_d  = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
            strb_d  = in_strb_i;
            side_d  = in_side_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            side_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            side_q  <= side_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_strb_o  = strb_q;
    assign out_side_o  = side_q;
endmodule

// File: rtl/sfm_streamer_tail_mask.sv
// rtl/sfm_streamer_tail_mask.sv - load-side tail mask: fills invalid trailing elements
module sfm_streamer_tail_mask
    import sfm_streamer_tail_mask_pkg::*;
#(
    parameter int unsigned    DW   = 128,
    parameter int unsigned    EW   = 16,
    parameter logic [EW-1:0]  FILL = SFM_BF16_NEG_INF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  hci_streamer_ctrl_t        stream_ctrl_i,
    sfm_streamer_tail_mask_if.slave   stream_i,
    sfm_streamer_tail_mask_if.master  stream_o,
    output logic                      last_o,
    output logic                      done_o
);
    localparam int unsigned BW = DW / 8;
    localparam int unsigned NE = DW / EW;
    localparam int unsigned EB = EW / 8;
    localparam int unsigned LW = $clog2(BW);

    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   tot_len;
    logic [LW-1:0] lftovr;
    logic          is_final;
    logic          in_ready;
    logic          in_hs;
    logic [NE-1:0] elem_valid;
    logic [DW-1:0] masked_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [BW-1:0] out_strb;
    logic          out_last;

    // Byte leftover of the job within the last beat; zero means a whole beat
    assign lftovr   = LW'(stream_ctrl_i.addressgen_ctrl.d0_len & 32'(BW - 1));
    assign tot_len  = stream_ctrl_i.addressgen_ctrl.tot_len;
    assign is_final = (cnt_q == (tot_len - 32'd1));
    assign in_hs    = stream_i.valid & in_ready;

    // Beat counter: wraps after the final beat so consecutive jobs need no clear
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (in_hs) begin
            cnt_d = is_final ? 32'd0 : (cnt_q + 32'd1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Replace every invalid element lane of the incoming beat with FILL
    always_comb begin
        masked_data = '0;
        elem_valid  = NE'(sfm_elem_valid_mask(SFM_MAX_BW'(stream_i.strb), 32'(lftovr),
                                              is_final, BW, EB));
        for (int unsigned e = 0; e < NE; e++) begin
            masked_data[e*EW +: EW] = elem_valid[e] ? stream_i.data[e*EW +: EW] : FILL;
        end
    end

    // Every output lane carries a defined value, so the output strobe is all ones
    sfm_stream_reg_slice #(
        .DW (DW),
        .BW (BW)
    ) i_out_slice (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (stream_i.valid),
        .in_ready_o  (in_ready),
        .in_data_i   (masked_data),
        .in_strb_i   ({BW{1'b1}}),
        .in_side_i   (is_final),
        .out_valid_o (out_valid),
        .out_ready_i (stream_o.ready),
        .out_data_o  (out_data),
        .out_strb_o  (out_strb),
        .out_side_o  (out_last)
    );

    assign stream_i.ready = in_ready;
    assign stream_o.valid = out_valid;
    assign stream_o.data  = out_data;
    assign stream_o.strb  = out_strb;
    assign last_o         = out_last;
    assign done_o         = out_valid & stream_o.ready & out_last;
endmodule

// File: tb/tb_sfm_streamer_tail_mask.sv
// tb/tb_sfm_streamer_tail_mask.sv - self-checking bench for sfm_streamer_tail_mask
module tb_sfm_streamer_tail_mask;
    import sfm_streamer_tail_mask_pkg::*;

    localparam int DW = 128;
    localparam int BW = 16;
    localparam int EW = 16;
    localparam int NE = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] strb;
        logic          last;
        logic          done;
    } obeat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } ebeat_t;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               clear_i;
    hci_streamer_ctrl_t ctrl;
    logic               last_o;
    logic               done_o;

    sfm_streamer_tail_mask_if #(.DW(DW)) s_in ();
    sfm_streamer_tail_mask_if #(.DW(DW)) s_out ();

    sfm_streamer_tail_mask #(
        .DW   (DW),
        .EW   (EW),
        .FILL (16'hFF80)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .stream_ctrl_i (ctrl),
        .stream_i      (s_in),
        .stream_o      (s_out),
        .last_o        (last_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int     errors = 0;
    int     checks = 0;
    int     done_cnt = 0;
    int     m_cnt = 0;
    int     m_tot = 1;
    int     m_d0 = 16;
    bit     rand_rdy_en = 1'b0;
    obeat_t got_q[$];
    ebeat_t exp_q[$];

    // Collect every output handshake and done pulse
    always @(negedge clk_i) begin
        if (s_out.valid && s_out.ready)
            got_q.push_back('{data: s_out.data, strb: s_out.strb, last: last_o, done: done_o});
        if (done_o) done_cnt++;
    end

    // Random output backpressure when enabled
    always @(posedge clk_i) begin
        #1;
        if (rand_rdy_en) s_out.ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: a job of d0 bytes; on its final beat only the first d0 mod BW
    // bytes are meaningful (all BW if it divides evenly). An element survives
    // only if it fits wholly in the meaningful bytes and all its bytes are strobed.
    function automatic logic [DW-1:0] ref_mask(input logic [DW-1:0] d, input logic [BW-1:0] s,
                                               input bit fin, input int d0);
        logic [DW-1:0] r;
        int            good_bytes;
        good_bytes = (fin && (d0 % BW) != 0) ? (d0 % BW) : BW;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            if (s[2*e] && s[2*e+1] && (2*e + 2) <= good_bytes) r[e*16 +: 16] = d[e*16 +: 16];
            else r[e*16 +: 16] = 16'hFF80;
        end
        return r;
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input logic [BW-1:0] s);
        bit fin;
        fin = (m_cnt == m_tot - 1);
        exp_q.push_back('{data: ref_mask(d, s, fin, m_d0), last: fin});
        m_cnt = fin ? 0 : m_cnt + 1;
    endtask

    task automatic set_job(input int d0, input int tot);
        m_d0 = d0;
        m_tot = tot;
        ctrl.addressgen_ctrl.d0_len  = 32'(d0);
        ctrl.addressgen_ctrl.tot_len = 32'(tot);
    endtask

    task automatic sb_reset();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge
    task automatic drive_beat(input logic [DW-1:0] d, input logic [BW-1:0] s);
        int t;
        bit ok;
        t = 0;
        s_in.valid = 1'b1;
        s_in.data  = d;
        s_in.strb  = s;
        do begin
            @(negedge clk_i);
            t++;
            ok = s_in.ready;
        end while (!ok && t < 300);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drive_timeout: stream_i.ready=%b after %0d cycles, required 1", ok, t);
        end
        @(posedge clk_i);
        #1;
        if (ok) model_accept(d, s);
        s_in.valid = 1'b0;
    endtask

    task automatic flush();
        rand_rdy_en = 1'b0;
        s_out.ready = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_i = 1'b0;
        s_in.valid = 1'b0;
        s_in.data = '0;
        s_in.strb = '0;
        s_out.ready = 1'b0;
        set_job(32, 3);
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (s_out.valid !== 1'b0 || s_out.data !== '0 || s_out.strb !== '0 || last_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h strb=%h last=%b done=%b, required all 0",
                     s_out.valid, s_out.data, s_out.strb, last_o, done_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        // Reset in the middle of a job: the next beat must be beat 0 again
        s_out.ready = 1'b1;
        drive_beat(rand_data(), 16'hFFFF);
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (s_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: stream_o.valid=%b, required 0", s_out.valid);
        end
        #2;
        rst_ni = 1'b1;
        m_cnt = 0;
        sb_reset();
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 3; k++) drive_beat(rand_data(), 16'hFFFF);
        flush();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_job_count: got %0d beats, required %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k].data !== exp_q[k].data || got_q[k].strb !== 16'hFFFF ||
                got_q[k].last !== exp_q[k].last || got_q[k].done !== exp_q[k].last) begin
                errors++;
                $display("FAIL reset_job_beat%0d: data=%h strb=%h last=%b done=%b, required data=%h strb=ffff last=%b done=%b",
                         k, got_q[k].data, got_q[k].strb, got_q[k].last, got_q[k].done,
                         exp_q[k].data, exp_q[k].last, exp_q[k].last);
            end
        end
    endtask

    task automatic test_full_job();
        logic [DW-1:0] a, b;
        sb_reset();
        set_job(32, 2);
        s_out.ready = 1'b1;
        a = rand_data();
        b = rand_data();
        drive_beat(a, 16'hFFFF);
        checks++;
        if (s_out.valid !== 1'b1 || s_out.data !== a || last_o !== 1'b0) begin
            errors++;
            $display("FAIL full_beat0: valid=%b data=%h last=%b, required valid=1 data=%h last=0",
                     s_out.valid, s_out.data, last_o, a);
        end
        drive_beat(b, 16'hFFFF);
        checks++;
        if (s_out.valid !== 1'b1 || s_out.data !== b || last_o !== 1'b1 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL full_beat1: valid=%b data=%h last=%b done=%b, required valid=1 data=%h last=1 done=1",
                     s_out.valid, s_out.data, last_o, done_o, b);
        end
        flush();
        checks++;
        if (done_cnt != 1 || got_q.size() != 2) begin
            errors++;
            $display("FAIL full_done_count: done pulses=%0d beats=%0d, required 1 and 2", done_cnt, got_q.size());
        end
    endtask

    task automatic test_leftover();
        logic [DW-1:0] d, e;
        sb_reset();
        set_job(22, 2);
        s_out.ready = 1'b1;
        drive_beat(rand_data(), 16'hFFFF);
        d = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        e = {{5{16'hFF80}}, 16'h0003, 16'h0002, 16'h0001};
        drive_beat(d, 16'hFFFF);
        checks++;
        if (s_out.data !== e || s_out.strb !== 16'hFFFF || last_o !== 1'b1) begin
            errors++;
            $display("FAIL leftover_tail: data=%h strb=%h last=%b, required data=%h strb=ffff last=1",
                     s_out.data, s_out.strb, last_o, e);
        end
        flush();
    endtask

    task automatic test_partial_elem();
        logic [DW-1:0] d, e;
        sb_reset();
        set_job(21, 1);
        s_out.ready = 1'b1;
        d = rand_data();
        e = {{6{16'hFF80}}, d[31:0]};
        drive_beat(d, 16'hFFFF);
        checks++;
        if (s_out.data !== e || last_o !== 1'b1 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_elem: data=%h last=%b done=%b, required data=%h last=1 done=1",
                     s_out.data, last_o, done_o, e);
        end
        flush();
    endtask

    task automatic test_strb_hole();
        logic [DW-1:0] d, e;
        sb_reset();
        set_job(32, 2);
        s_out.ready = 1'b1;
        d = rand_data();
        e = d;
        e[31:16] = 16'hFF80;
        drive_beat(d, 16'hFFF3);
        checks++;
        if (s_out.data !== e || s_out.strb !== 16'hFFFF || last_o !== 1'b0) begin
            errors++;
            $display("FAIL strb_hole: data=%h strb=%h last=%b, required data=%h strb=ffff last=0",
                     s_out.data, s_out.strb, last_o, e);
        end
        drive_beat(rand_data(), 16'hFFFF);
        checks++;
        if (last_o !== 1'b1) begin
            errors++;
            $display("FAIL strb_hole_last: last=%b, required 1", last_o);
        end
        flush();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        sb_reset();
        set_job(32, 2);
        s_out.ready = 1'b0;
        a = rand_data();
        b = rand_data();
        drive_beat(a, 16'hFFFF);
        s_in.valid = 1'b1;
        s_in.data = b;
        s_in.strb = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (s_in.ready !== 1'b0 || s_out.valid !== 1'b1 || s_out.data !== a || last_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: in_ready=%b valid=%b data=%h last=%b, required in_ready=0 valid=1 data=%h last=0",
                         k, s_in.ready, s_out.valid, s_out.data, last_o, a);
            end
        end
        @(posedge clk_i);
        #1;
        s_out.ready = 1'b1;
        drive_beat(b, 16'hFFFF);
        flush();
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL stall_count: got %0d beats, required 2", got_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k].data !== exp_q[k].data || got_q[k].last !== exp_q[k].last || got_q[k].done !== exp_q[k].last) begin
                errors++;
                $display("FAIL stall_beat%0d: data=%h last=%b done=%b, required data=%h last=%b done=%b",
                         k, got_q[k].data, got_q[k].last, got_q[k].done, exp_q[k].data, exp_q[k].last, exp_q[k].last);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_reset();
        set_job(48, 3);
        rand_rdy_en = 1'b1;
        for (int k = 0; k < 6; k++) drive_beat(rand_data(), 16'hFFFF);
        flush();
        checks++;
        if (done_cnt != 2 || got_q.size() != 6) begin
            errors++;
            $display("FAIL b2b_count: done pulses=%0d beats=%0d, required 2 and 6", done_cnt, got_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k].data !== exp_q[k].data || got_q[k].strb !== 16'hFFFF ||
                got_q[k].last !== exp_q[k].last || got_q[k].done !== exp_q[k].last) begin
                errors++;
                $display("FAIL b2b_beat%0d: data=%h strb=%h last=%b done=%b, required data=%h strb=ffff last=%b done=%b",
                         k, got_q[k].data, got_q[k].strb, got_q[k].last, got_q[k].done,
                         exp_q[k].data, exp_q[k].last, exp_q[k].last);
            end
        end
    endtask

    task automatic test_clear();
        sb_reset();
        set_job(64, 4);
        s_out.ready = 1'b1;
        drive_beat(rand_data(), 16'hFFFF);
        s_in.valid = 1'b1;
        s_in.data = rand_data();
        s_in.strb = 16'hFFFF;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        s_in.valid = 1'b0;
        m_cnt = 0;
        checks++;
        if (s_out.valid !== 1'b0 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_output: valid=%b last=%b, required valid=0 last=0", s_out.valid, last_o);
        end
        for (int k = 0; k < 4; k++) drive_beat(rand_data(), 16'hFFFF);
        flush();
        checks++;
        if (done_cnt != 1 || got_q.size() != 5) begin
            errors++;
            $display("FAIL clear_count: done pulses=%0d beats=%0d, required 1 and 5", done_cnt, got_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k].data !== exp_q[k].data || got_q[k].last !== exp_q[k].last || got_q[k].done !== exp_q[k].last) begin
                errors++;
                $display("FAIL clear_beat%0d: data=%h last=%b done=%b, required data=%h last=%b done=%b",
                         k, got_q[k].data, got_q[k].last, got_q[k].done, exp_q[k].data, exp_q[k].last, exp_q[k].last);
            end
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] s;
        int            njobs;
        sb_reset();
        njobs = 8;
        rand_rdy_en = 1'b1;
        for (int j = 0; j < njobs; j++) begin
            set_job($urandom_range(1, 80), $urandom_range(1, 5));
            for (int k = 0; k < m_tot; k++) begin
                s = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
                repeat ($urandom_range(0, 2)) @(posedge clk_i);
                #1;
                drive_beat(rand_data(), s);
            end
        end
        flush();
        checks++;
        if (done_cnt != njobs || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: done pulses=%0d beats=%0d, required %0d and %0d",
                     done_cnt, got_q.size(), njobs, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k].data !== exp_q[k].data || got_q[k].strb !== 16'hFFFF ||
                got_q[k].last !== exp_q[k].last || got_q[k].done !== exp_q[k].last) begin
                errors++;
                $display("FAIL rand_beat%0d: data=%h strb=%h last=%b done=%b, required data=%h strb=ffff last=%b done=%b",
                         k, got_q[k].data, got_q[k].strb, got_q[k].last, got_q[k].done,
                         exp_q[k].data, exp_q[k].last, exp_q[k].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_leftover();
        test_partial_elem();
        test_strb_hole();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
